bcd_conv_sched: RTL
===================

// Module: bcd_conv_sched
// PURPOSE
//  Time-shares one combinational bin2bcd converter among three binary time fields:
//  seconds, minutes and hours.
//  Per-channel update requests are latched as sticky pending flags.
//  A round-robin arbiter grants one channel per clock and drives the shared converter.
//  The converted digits are captured into per-channel BCD registers that feed the display mux.
//  Sits between the time counters and the 7-segment decode/scan logic.
// PARAMETERS
//  SEC_MAX   59     largest legal seconds value; larger values are out of range
//  MIN_MAX   59     largest legal minutes value
//  HOUR_MAX  23     largest legal hours value
//  BLANK     4'hF   digit code written to both digits of an out-of-range channel
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  sec_bin      in   6  seconds value (binary)
//  min_bin      in   6  minutes value (binary)
//  hour_bin     in   5  hours value (binary), zero-extended to 6 bits for conversion
//  req          in   3  update request pulses; [0]=sec, [1]=min, [2]=hour
//  refresh_all  in   1  sets all three pending flags
//  conv_bin     out  6  registered operand to the shared bin2bcd converter
//  conv_units   in   4  converter units digit (combinational from conv_bin)
//  conv_tens    in   4  converter tens digit
//  sec_u/sec_t  out  4  seconds units/tens BCD, registered
//  min_u/min_t  out  4  minutes units/tens BCD, registered
//  hr_u/hr_t    out  4  hours units/tens BCD, registered
//  done         out  3  one-cycle pulse per channel when its digits are updated
//  busy         out  1  high while the state is CONV
//  range_err    out  1  sticky flag: an out-of-range value was converted; cleared only by rst
// BEHAVIOUR
//  Reset (async, any time, including mid-conversion):
//   - state=IDLE, pending=0, conv_bin=0, all digit outputs=0, done=0, busy=0, range_err=0.
//   - The round-robin pointer is set to 2, so the first grant after reset goes to sec.
//  Pending flags:
//   - pending[i] is set on any edge where req[i] or refresh_all is high.
//   - pending[i] is cleared on the edge that issues channel i.
//   - If set and clear coincide, set wins: the channel is re-converted later with its newer value.
//  Arbitration: the winner is the first pending channel searching ptr+1, ptr+2, ptr+3 (mod 3).
//   ptr is loaded with the winner on every issue.
//  FSM, two states:
//   IDLE: if any pending at the edge -> issue the winner, go to CONV; else stay in IDLE.
//   CONV: capture, then if any pending (flags after this edge's clear) -> issue the next winner
//         and stay in CONV; else go to IDLE.
//  Issue (on the edge):
//   - conv_bin <= selected input value; gnt_r <= winner.
//   - oor_r <= 1 if the value exceeds that channel's *_MAX.
//   - The input is sampled at the issue edge; later input changes do not affect this conversion.
//  Capture (on the edge leaving each CONV cycle):
//   - If oor_r=0: the gnt_r channel's units/tens <= conv_units/conv_tens.
//   - If oor_r=1: both digits <= BLANK and range_err <= 1.
//   - done[gnt_r] is high for the following cycle only.
//  Other channels' digits hold their values. Throughput is one conversion per clock.
//  Latency: req sampled at edge E0 -> issued at E1 (from IDLE) -> digits and done valid after E2.
//  busy = (state==CONV). The converter is combinational; no handshake on conv_* ports.
// TESTING
//  1. Reset, sec_bin=37, pulse req[0] -> two edges later sec_t=3, sec_u=7, done=3'b001 for one cycle.
//  2. Pulse req=3'b111 (sec=5, min=42, hr=19) -> grants sec, min, hr on consecutive clocks;
//     digits 05/42/19; busy high for exactly 3 cycles.
//  3. Hold sec pending while repeatedly pulsing req[1], then req[2]
//     -> grants rotate sec->min->hr; no channel is starved.
//  4. Pulse req[0] in the same cycle sec is being issued, changing sec_bin 10->11
//     -> sec converts twice; final digits 1/1.
//  5. min_bin=61, req[1] -> min_t=min_u=4'hF, range_err=1 and sticky;
//     then min_bin=8 -> digits 0/8, range_err remains 1.
//  6. Assert rst during CONV with pending=3'b110 -> all outputs 0, pending cleared;
//     the next refresh_all yields grant order sec, min, hr.

Source files
------------

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - round-robin time-share of one bin2bcd converter over sec/min/hour fields
module bcd_conv_sched #(
    parameter int          SEC_MAX  = 59,
    parameter int          MIN_MAX  = 59,
    parameter int          HOUR_MAX = 23,
    parameter logic [3:0]  BLANK    = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec_bin,
    input  logic [5:0] min_bin,
    input  logic [4:0] hour_bin,
    input  logic [2:0] req,
    input  logic       refresh_all,
    output logic [5:0] conv_bin,
    input  logic [3:0] conv_units,
    input  logic [3:0] conv_tens,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic [3:0] hr_u,
    output logic [3:0] hr_t,
    output logic [2:0] done,
    output logic       busy,
    output logic       range_err
);

    localparam logic IDLE = 1'b0;
    localparam logic CONV = 1'b1;

    localparam logic [5:0] SEC_LIM  = 6'(SEC_MAX);
    localparam logic [5:0] MIN_LIM  = 6'(MIN_MAX);
    localparam logic [5:0] HOUR_LIM = 6'(HOUR_MAX);

    logic       state_q, state_d;
    logic [2:0] pending_q, pending_d;
    logic [1:0] ptr_q;
    logic [1:0] gnt_q;
    logic       oor_q;
    logic [5:0] conv_bin_q;
    logic [3:0] sec_u_q, sec_t_q, min_u_q, min_t_q, hr_u_q, hr_t_q;
    logic [2:0] done_q;
    logic       range_err_q;

    logic [1:0] cand1, cand2, cand3;
    logic       win_valid;
    logic [1:0] win;
    logic [5:0] sel_val;
    logic       sel_oor;
    logic [2:0] clr_mask;

    // Channel index (p + k) mod 3, for p in 0..2 and k in 1..3.
    function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Round-robin search starting just after the last issued channel.
    always_comb begin
        cand1     = rr_idx(ptr_q, 2'd1);
        cand2     = rr_idx(ptr_q, 2'd2);
        cand3     = rr_idx(ptr_q, 2'd3);
        win_valid = 1'b1;
        win       = cand1;
        if (pending_q[cand1]) begin
            win = cand1;
        end else if (pending_q[cand2]) begin
            win = cand2;
        end else if (pending_q[cand3]) begin
            win = cand3;
        end else begin
            win_valid = 1'b0;
        end
    end

    // Operand mux and range check for the winning channel.
    always_comb begin
        sel_val = 6'd0;
        sel_oor = 1'b0;
        case (win)
            2'd0: begin
                sel_val = sec_bin;
                sel_oor = sec_bin > SEC_LIM;
            end
            2'd1: begin
                sel_val = min_bin;
                sel_oor = min_bin > MIN_LIM;
            end
            2'd2: begin
                sel_val = {1'b0, hour_bin};
                sel_oor = {1'b0, hour_bin} > HOUR_LIM;
            end
            default: begin
                sel_val = 6'd0;
                sel_oor = 1'b0;
            end
        endcase
    end

    // Pending update: issue clears the winner, but a same-edge request re-sets it.
    always_comb begin
        clr_mask  = win_valid ? (3'b001 << win) : 3'b000;
        pending_d = (pending_q & ~clr_mask) | req | {3{refresh_all}};
    end

    // Next state: keep converting back-to-back while anything is pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = win_valid ? CONV : IDLE;
            CONV:    state_d = win_valid ? CONV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM, pending flags and issue registers (operand, grant, out-of-range tag).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 3'b000;
            ptr_q      <= 2'd2;
            gnt_q      <= 2'd0;
            oor_q      <= 1'b0;
            conv_bin_q <= 6'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (win_valid) begin
                ptr_q      <= win;
                gnt_q      <= win;
                oor_q      <= sel_oor;
                conv_bin_q <= sel_val;
            end
        end
    end

    // Capture converter result (or blank) into the granted channel's digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_u_q     <= 4'd0;
            sec_t_q     <= 4'd0;
            min_u_q     <= 4'd0;
            min_t_q     <= 4'd0;
            hr_u_q      <= 4'd0;
            hr_t_q      <= 4'd0;
            range_err_q <= 1'b0;
        end else if (state_q == CONV) begin
            if (oor_q) begin
                range_err_q <= 1'b1;
            end
            case (gnt_q)
                2'd0: begin
                    sec_u_q <= oor_q ? BLANK : conv_units;
                    sec_t_q <= oor_q ? BLANK : conv_tens;
                end
                2'd1: begin
                    min_u_q <= oor_q ? BLANK : conv_units;
                    min_t_q <= oor_q ? BLANK : conv_tens;
                end
                2'd2: begin
                    hr_u_q <= oor_q ? BLANK : conv_units;
                    hr_t_q <= oor_q ? BLANK : conv_tens;
                end
                default: begin
                end
            endcase
        end
    end

    // One-cycle done pulse for the channel captured on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 3'b000;
        end else begin
            done_q <= (state_q == CONV) ? (3'b001 << gnt_q) : 3'b000;
        end
    end

    assign conv_bin  = conv_bin_q;
    assign sec_u     = sec_u_q;
    assign sec_t     = sec_t_q;
    assign min_u     = min_u_q;
    assign min_t     = min_t_q;
    assign hr_u      = hr_u_q;
    assign hr_t      = hr_t_q;
    assign done      = done_q;
    assign busy      = (state_q == CONV);
    assign range_err = range_err_q;

endmodule
